// File: rtl/eth_rx_pkg.sv
// Shared definitions for the MII receive path.
// Contents:
//   rx_state_e   deframer FSM state encoding
//   CRC_*        IEEE 802.3 CRC-32 constants (reflected form, LSB first)
//   ERR_*        bit positions inside the rx_err status word
//   crc32_d8     one-byte CRC-32 update, LSB of the byte first
package eth_rx_pkg;

    localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    // Register value left after running data plus its own FCS through the CRC
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam int ERR_ODD      = 0;
    localparam int ERR_RUNT     = 1;
    localparam int ERR_OVERSIZE = 2;
    localparam int ERR_RXER     = 3;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_PREAMBLE  = 3'd2,
        ST_DATA      = 3'd3,
        ST_DONE      = 3'd4,
        ST_DROP      = 3'd5
    } rx_state_e;

    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_d8_chk.sv
// Byte-wide CRC-32 accumulator used to check the Ethernet FCS.
// Ports:
//   clk   in   clock
//   rst   in   synchronous reset, active-high (loads all-ones)
//   clr   in   reload all-ones (start of a new frame)
//   en    in   fold data into the CRC this clock
//   data  in   byte to fold in, LSB first
//   crc   out  current CRC register (no final inversion)
module eth_crc32_d8_chk
    import eth_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    // CRC register: reset/clear to all-ones, otherwise fold in enabled bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_d8(crc, data);
        end else begin
            crc <= crc;
        end
    end

endmodule

// File: rtl/mii_rx_frame_deframer.sv
// MII receive front end: strips preamble/SFD, packs LSN-first nibbles into
// bytes, checks the FCS and reports one status strobe per frame.
// Ports:
//   clk, rst               MII RX clock, synchronous active-high reset
//   eth_rxdv/rxer/rx_data  MII RX pins
//   rx_byte, rx_byte_vld   assembled byte and its 1-clk strobe
//   rx_sop                 marks the first byte of a frame
//   rx_done                1-clk end-of-frame strobe
//   rx_len/fcs_ok/err      frame status, updated with rx_done and held
module mii_rx_frame_deframer
    import eth_rx_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             eth_rxdv,
    input  logic             eth_rxer,
    input  logic [3:0]       eth_rx_data,
    output logic [7:0]       rx_byte,
    output logic             rx_byte_vld,
    output logic             rx_sop,
    output logic             rx_done,
    output logic [LEN_W-1:0] rx_len,
    output logic             rx_fcs_ok,
    output logic [3:0]       rx_err
);

    localparam logic [LEN_W-1:0] CNT_SAT = {LEN_W{1'b1}};

    rx_state_e        state_r;
    rx_state_e        state_nxt_s;
    logic             rxdv_r;
    logic             rxer_r;
    logic [3:0]       rxd_r;
    logic [3:0]       lo_nib_r;
    logic             phase_hi_r;
    logic [LEN_W-1:0] cnt_r;
    logic             sop_pend_r;
    logic             oversize_r;
    logic             rxer_seen_r;
    logic [31:0]      crc_s;
    logic             nib_vld_s;
    logic             byte_done_s;
    logic             over_s;
    logic             byte_emit_s;
    logic             frame_end_s;
    logic             enter_data_s;
    logic             crc_clr_s;
    logic [LEN_W-1:0] cnt_nxt_s;
    logic [3:0]       err_s;

    // Input capture; left free-running through reset so that rxdv_r shows a
    // frame already on the wire the moment reset is released
    always_ff @(posedge clk) begin
        rxdv_r <= eth_rxdv;
        rxer_r <= eth_rxer;
        rxd_r  <= eth_rx_data;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_WAIT_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_WAIT_IDLE: state_nxt_s = rxdv_r ? ST_WAIT_IDLE : ST_IDLE;
            ST_IDLE: begin
                if (rxdv_r) begin
                    state_nxt_s = (rxd_r == 4'h5) ? ST_PREAMBLE : ST_DROP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (!rxdv_r) begin
                    state_nxt_s = ST_IDLE;
                end else if (rxd_r == 4'h5) begin
                    state_nxt_s = ST_PREAMBLE;
                end else if (rxd_r == 4'hD) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            ST_DATA:  state_nxt_s = rxdv_r ? ST_DATA : ST_DONE;
            ST_DONE:  state_nxt_s = ST_IDLE;
            ST_DROP:  state_nxt_s = rxdv_r ? ST_DROP : ST_IDLE;
            default:  state_nxt_s = ST_WAIT_IDLE;
        endcase
    end

    // Datapath decode: byte completion, MAX_FRAME suppression, status word
    always_comb begin
        nib_vld_s    = (state_r == ST_DATA) && rxdv_r;
        byte_done_s  = nib_vld_s && phase_hi_r;
        // The byte that would make the count exceed MAX_FRAME is already suppressed
        over_s       = (cnt_r >= LEN_W'(MAX_FRAME));
        byte_emit_s  = byte_done_s && !over_s;
        frame_end_s  = (state_r == ST_DATA) && !rxdv_r;
        enter_data_s = (state_r == ST_PREAMBLE) && (state_nxt_s == ST_DATA);
        crc_clr_s    = (state_nxt_s == ST_IDLE) && (state_r != ST_IDLE);
        cnt_nxt_s    = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + 1'b1);
        err_s               = 4'b0000;
        err_s[ERR_ODD]      = phase_hi_r;
        err_s[ERR_RUNT]     = (cnt_r < LEN_W'(MIN_FRAME));
        err_s[ERR_OVERSIZE] = oversize_r;
        err_s[ERR_RXER]     = rxer_seen_r;
    end

    // Per-frame bookkeeping: nibble phase, byte count, flags
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_nib_r    <= 4'h0;
            phase_hi_r  <= 1'b0;
            cnt_r       <= '0;
            sop_pend_r  <= 1'b0;
            oversize_r  <= 1'b0;
            rxer_seen_r <= 1'b0;
        end else if (enter_data_s) begin
            phase_hi_r  <= 1'b0;
            cnt_r       <= '0;
            sop_pend_r  <= 1'b1;
            oversize_r  <= 1'b0;
            rxer_seen_r <= 1'b0;
        end else if (nib_vld_s) begin
            phase_hi_r <= ~phase_hi_r;
            if (!phase_hi_r) begin
                lo_nib_r <= rxd_r;
            end
            if (byte_done_s) begin
                cnt_r <= cnt_nxt_s;
            end
            if (byte_done_s && over_s) begin
                oversize_r <= 1'b1;
            end
            if (byte_emit_s) begin
                sop_pend_r <= 1'b0;
            end
            if (rxer_r) begin
                rxer_seen_r <= 1'b1;
            end
        end
    end

    // Registered byte stream and frame status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte     <= 8'h00;
            rx_byte_vld <= 1'b0;
            rx_sop      <= 1'b0;
            rx_done     <= 1'b0;
            rx_len      <= '0;
            rx_fcs_ok   <= 1'b0;
            rx_err      <= 4'b0000;
        end else begin
            rx_byte_vld <= byte_emit_s;
            rx_sop      <= byte_emit_s && sop_pend_r;
            rx_done     <= frame_end_s;
            if (byte_emit_s) begin
                rx_byte <= {rxd_r, lo_nib_r};
            end
            if (frame_end_s) begin
                rx_len    <= cnt_r;
                rx_fcs_ok <= (crc_s == CRC_RESIDUE) && !phase_hi_r;
                rx_err    <= err_s;
            end
        end
    end

    eth_crc32_d8_chk u_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (crc_clr_s),
        .en   (byte_emit_s),
        .data ({rxd_r, lo_nib_r}),
        .crc  (crc_s)
    );

endmodule
